// File: rtl/bit_count_engine.sv
// Multi-cycle population counter: counts ones or zeros of a WIDTH-bit word, CHUNK bits per clock,
// with valid/ready on both sides. Optional macro BIT_COUNT_FIRST_ONE_EN adds a lowest-set-bit finder.
module bit_count_engine #(
    parameter  int WIDTH = 8,
    parameter  int CHUNK = 1,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int FW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk_i,
    input  logic          srst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic          mode_i,
    input  logic          data_val_i,
    output logic          data_ready_o,
    output logic [CW-1:0] data_o,
    output logic          data_val_o,
`ifdef BIT_COUNT_FIRST_ONE_EN
    output logic [FW-1:0] first_idx_o,
    output logic          first_vld_o,
`endif
    input  logic          data_ready_i
);

    localparam int NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW         = NUM_CHUNKS * CHUNK;
    localparam int IW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [CW-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             mode_q, mode_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    data_q, data_d;
    logic             ready_q, ready_d;
    logic             val_q, val_d;

    logic [PW-1:0]    padded_s;
    logic [CHUNK-1:0] chunk_s;
    logic [CW-1:0]    chunk_cnt_s;
    int               base_s;

    // Current chunk after polarity selection; padding is applied after the flip so it never counts.
    always_comb begin
        padded_s              = '0;
        padded_s[WIDTH-1:0]   = word_q ^ {WIDTH{mode_q}};
        base_s                = int'(idx_q) * CHUNK;
        chunk_s               = padded_s[base_s +: CHUNK];
        chunk_cnt_s           = popcount(chunk_s);
    end

    // FSM next-state and datapath
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        data_d  = data_q;
        ready_d = ready_q;
        val_d   = val_q;
        case (state_q)
            ST_IDLE: begin
                if (data_val_i && ready_q) begin
                    word_d  = data_i;
                    mode_d  = mode_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                acc_d = acc_q + chunk_cnt_s;
                if (idx_q == LAST_IDX) begin
                    data_d  = acc_q + chunk_cnt_s;
                    idx_d   = '0;
                    val_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_COUNT;
                end
            end
            ST_DONE: begin
                if (data_ready_i) begin
                    val_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                val_d   = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            val_q   <= val_d;
        end
    end

    assign data_ready_o = ready_q;
    assign data_val_o   = val_q;
    assign data_o       = data_q;

`ifdef BIT_COUNT_FIRST_ONE_EN
    logic [PW-1:0]    raw_pad_s;
    logic [CHUNK-1:0] raw_chunk_s;
    logic             hit_s;
    int               off_s;
    logic             fvld_w_q, fvld_w_d;
    logic [FW-1:0]    fidx_w_q, fidx_w_d;
    logic             first_vld_q, first_vld_d;
    logic [FW-1:0]    first_idx_q, first_idx_d;

    // Lowest set bit of the raw word, scanned chunk by chunk alongside the count
    always_comb begin
        raw_pad_s            = '0;
        raw_pad_s[WIDTH-1:0] = word_q;
        raw_chunk_s          = raw_pad_s[base_s +: CHUNK];
        hit_s                = 1'b0;
        off_s                = 0;
        for (int j = CHUNK - 1; j >= 0; j--) begin
            if (raw_chunk_s[j]) begin
                hit_s = 1'b1;
                off_s = j;
            end else begin
                hit_s = hit_s;
            end
        end
        fvld_w_d    = fvld_w_q;
        fidx_w_d    = fidx_w_q;
        first_vld_d = first_vld_q;
        first_idx_d = first_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (data_val_i && ready_q) begin
                    fvld_w_d = 1'b0;
                    fidx_w_d = '0;
                end else begin
                    fvld_w_d = fvld_w_q;
                end
            end
            ST_COUNT: begin
                if (!fvld_w_q && hit_s) begin
                    fvld_w_d = 1'b1;
                    fidx_w_d = FW'(base_s + off_s);
                end else begin
                    fvld_w_d = fvld_w_q;
                end
                if (idx_q == LAST_IDX) begin
                    first_vld_d = fvld_w_d;
                    first_idx_d = fidx_w_d;
                end else begin
                    first_vld_d = first_vld_q;
                end
            end
            ST_DONE: begin
                fvld_w_d = fvld_w_q;
            end
            default: begin
                fvld_w_d = 1'b0;
                fidx_w_d = '0;
            end
        endcase
    end

    // First-one registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            fvld_w_q    <= 1'b0;
            fidx_w_q    <= '0;
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
        end else begin
            fvld_w_q    <= fvld_w_d;
            fidx_w_q    <= fidx_w_d;
            first_vld_q <= first_vld_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign first_vld_o = first_vld_q;
    assign first_idx_o = first_idx_q;
`endif

endmodule
